// File: rtl/tx_buffer_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding and default widths.
package tx_buffer_pkg;

  localparam int unsigned TXB_DATA_BITS = 8;
  localparam int unsigned TXB_ADDR_BITS = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

endpackage : tx_buffer_pkg

// File: rtl/tx_buffer_fifo_sync.sv
// Synchronous FIFO with registered count/full/empty; the head word is read combinationally.
// TX_BUFFER_LEVEL_EN exposes the registered count on o_count.
module fifo_sync
  import tx_buffer_pkg::*;
#(
  parameter int unsigned DATA_BITS = TXB_DATA_BITS,
  parameter int unsigned ADDR_BITS = TXB_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_rd,
  output logic [DATA_BITS-1:0] o_head_c,
  output logic                 o_full,
  output logic                 o_empty
`ifdef TX_BUFFER_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]   o_count
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;
  logic                 r_empty;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic [CNT_W-1:0]     w_count_nxt;

  // Full gates the write on the registered count, so a same-cycle pop never frees a slot.
  assign w_wr_acc = i_wr && !r_full;
  assign w_rd_acc = i_rd && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_full   = r_full;
  assign o_empty  = r_empty;
`ifdef TX_BUFFER_LEVEL_EN
  assign o_count  = r_count;
`endif

endmodule : fifo_sync

// File: rtl/tx_buffer.sv
// Transmit front-end: queues producer bytes and hands them to the UART transmitter one at a time.
// TX_BUFFER_LEVEL_EN adds the o_level output (registered FIFO count).
module tx_buffer
  import tx_buffer_pkg::*;
#(
  parameter int unsigned DATA_BITS = TXB_DATA_BITS,
  parameter int unsigned ADDR_BITS = TXB_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_clr_ovf,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_overflow,
  output logic                 o_tx_start,
  output logic [DATA_BITS-1:0] o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy
`ifdef TX_BUFFER_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]   o_level
`endif
);

  tx_state_e            r_state;
  logic                 r_tx_start;
  logic [DATA_BITS-1:0] r_tx_data;
  logic                 r_busy;
  logic                 r_overflow;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;

  fifo_sync #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .i_rd      (w_pop),
    .o_head_c  (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
`ifdef TX_BUFFER_LEVEL_EN
    ,
    .o_count   (o_level)
`endif
  );

  assign w_pop = (r_state == ST_IDLE) && !w_empty;

  // Pop, latch the word and pulse start in one edge; then hold until the transmitter reports done.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (i_wr && w_full) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;

endmodule : tx_buffer
